// File: rtl/band_power_accum.sv
// Per-band energy accumulator for the ten-bar display. It sums band magnitudes per window,
// then scales a snapshot serially and publishes all ten bins at once.
module band_power_accum #(
  parameter int ACC_W = 28,
  parameter int SHIFT = 11
) (
  input  logic        sample_clk,
  input  logic        rst_n,
  input  logic        band_valid,
  input  logic [3:0]  band_idx,
  input  logic [11:0] band_mag,
  input  logic        set_values_flag,
  output logic [11:0] bin1_out,
  output logic [11:0] bin2_out,
  output logic [11:0] bin3_out,
  output logic [11:0] bin4_out,
  output logic [11:0] bin5_out,
  output logic [11:0] bin6_out,
  output logic [11:0] bin7_out,
  output logic [11:0] bin8_out,
  output logic [11:0] bin9_out,
  output logic [11:0] bin10_out,
  output logic        values_ready,
  output logic        busy,
  output logic        overrun
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCALE  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q [10];
  logic [ACC_W-1:0]  acc_d [10];
  logic [ACC_W-1:0]  shd_q [10];
  logic [ACC_W-1:0]  shd_d [10];
  logic [11:0]       stg_q [10];
  logic [11:0]       stg_d [10];
  logic [11:0]       bin_q [10];
  logic [11:0]       bin_d [10];
  logic [3:0]        k_q, k_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              accept_s;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [11:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s[ACC_W]) begin
      return '1;
    end else begin
      return s[ACC_W-1:0];
    end
  endfunction

  function automatic logic [11:0] clamp12(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] sh;
    sh = v >> SHIFT;
    if (sh > ACC_W'(12'hFFF)) begin
      return 12'hFFF;
    end else begin
      return sh[11:0];
    end
  endfunction

  assign accept_s = (state_q == S_IDLE) && set_values_flag;

  // Window accumulation, snapshot/scale/commit sequencing and flag bookkeeping
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    shd_d     = shd_q;
    stg_d     = stg_q;
    bin_d     = bin_q;
    ready_d   = 1'b0;
    overrun_d = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (accept_s) begin
        acc_d[i] = '0;
      end else begin
        acc_d[i] = acc_q[i];
      end
      // A sample on the accepting edge seeds the new window instead of the old one
      if (band_valid && (band_idx == 4'(i))) begin
        if (accept_s) begin
          acc_d[i] = ACC_W'(band_mag);
        end else begin
          acc_d[i] = sat_add(acc_q[i], band_mag);
        end
      end else begin
        acc_d[i] = acc_d[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (set_values_flag) begin
          shd_d   = acc_q;
          k_d     = 4'd0;
          state_d = S_SCALE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCALE: begin
        overrun_d = set_values_flag;
        for (int i = 0; i < 10; i++) begin
          if (k_q == 4'(i)) begin
            stg_d[i] = clamp12(shd_q[i]);
          end else begin
            stg_d[i] = stg_q[i];
          end
        end
        if (k_q == 4'd9) begin
          state_d = S_COMMIT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_COMMIT: begin
        overrun_d = set_values_flag;
        bin_d     = stg_q;
        ready_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and storage registers
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= 4'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        acc_q[i] <= '0;
        shd_q[i] <= '0;
        stg_q[i] <= 12'd0;
        bin_q[i] <= 12'd0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      acc_q     <= acc_d;
      shd_q     <= shd_d;
      stg_q     <= stg_d;
      bin_q     <= bin_d;
    end
  end

  assign bin1_out     = bin_q[0];
  assign bin2_out     = bin_q[1];
  assign bin3_out     = bin_q[2];
  assign bin4_out     = bin_q[3];
  assign bin5_out     = bin_q[4];
  assign bin6_out     = bin_q[5];
  assign bin7_out     = bin_q[6];
  assign bin8_out     = bin_q[7];
  assign bin9_out     = bin_q[8];
  assign bin10_out    = bin_q[9];
  assign values_ready = ready_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_band_power_accum.sv
// Directed bench for band_power_accum: default-width instance plus a narrow
// instance (ACC_W=16, SHIFT=4) sharing the same stimulus for the saturation case.
module tb_band_power_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        band_valid = 1'b0;
  logic [3:0]  band_idx = 4'd0;
  logic [11:0] band_mag = 12'd0;
  logic        set_values_flag = 1'b0;

  logic [11:0] bin_o [10];
  logic        values_ready, busy, overrun;
  logic [11:0] sat_o [10];
  logic        sat_ready, sat_busy, sat_overrun;

  int tests = 0;
  int fails = 0;
  int exp_bins [10];
  int lat, pulses, cnt;

  always #5 clk = ~clk;

  band_power_accum u_dut (
    .sample_clk(clk), .rst_n(rst_n), .band_valid(band_valid), .band_idx(band_idx),
    .band_mag(band_mag), .set_values_flag(set_values_flag),
    .bin1_out(bin_o[0]), .bin2_out(bin_o[1]), .bin3_out(bin_o[2]), .bin4_out(bin_o[3]),
    .bin5_out(bin_o[4]), .bin6_out(bin_o[5]), .bin7_out(bin_o[6]), .bin8_out(bin_o[7]),
    .bin9_out(bin_o[8]), .bin10_out(bin_o[9]),
    .values_ready(values_ready), .busy(busy), .overrun(overrun)
  );

  band_power_accum #(.ACC_W(16), .SHIFT(4)) u_sat (
    .sample_clk(clk), .rst_n(rst_n), .band_valid(band_valid), .band_idx(band_idx),
    .band_mag(band_mag), .set_values_flag(set_values_flag),
    .bin1_out(sat_o[0]), .bin2_out(sat_o[1]), .bin3_out(sat_o[2]), .bin4_out(sat_o[3]),
    .bin5_out(sat_o[4]), .bin6_out(sat_o[5]), .bin7_out(sat_o[6]), .bin8_out(sat_o[7]),
    .bin9_out(sat_o[8]), .bin10_out(sat_o[9]),
    .values_ready(sat_ready), .busy(sat_busy), .overrun(sat_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bins(input string tag);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_bin%0d", tag, i + 1), int'(bin_o[i]), exp_bins[i]);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 10; i++) exp_bins[i] = v;
  endtask

  task automatic feed(input logic [3:0] idx, input logic [11:0] mag, input int n);
    band_valid = 1'b1;
    band_idx   = idx;
    band_mag   = mag;
    repeat (n) tick();
    band_valid = 1'b0;
  endtask

  // Flag on edge T (optionally with a sample), then watch edges T+1..T+13
  task automatic publish(input logic v, input logic [3:0] idx, input logic [11:0] mag,
                         output int lat_o, output int pulses_o);
    set_values_flag = 1'b1;
    band_valid      = v;
    band_idx        = idx;
    band_mag        = mag;
    tick();
    set_values_flag = 1'b0;
    band_valid      = 1'b0;
    lat_o    = 0;
    pulses_o = 0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (values_ready) begin
        pulses_o++;
        if (lat_o == 0) lat_o = c;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    set_all(0);
    chk_bins("reset");
    chk("reset_ready", int'(values_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // Accumulator saturation on the narrow instance: 40*4095 > 65535
    feed(4'd9, 12'd4095, 40);
    chk("sat_acc_hold", int'(u_sat.acc_q[9]), 65535);
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    chk("sat_bin10", int'(sat_o[9]), 4095);
    chk("wide_bin10", int'(bin_o[9]), 79);
    chk("sat_latency", lat, 11);
    chk("sat_pulses", pulses, 1);
    chk("sat_busy_after", int'(busy), 0);

    // Basic scaling: 2048 * 100 >> 11 = 100
    feed(4'd3, 12'd100, 2048);
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    set_all(0);
    exp_bins[3] = 100;
    chk_bins("basic");
    chk("basic_latency", lat, 11);
    chk("basic_pulses", pulses, 1);

    // Output clamp, then an empty window
    feed(4'd0, 12'd4095, 4096);
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    set_all(0);
    exp_bins[0] = 4095;
    chk_bins("clamp");
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    set_all(0);
    chk_bins("empty");

    // Band mapping: band i gets i+1 samples of 2048; indices 10 and 15 ignored
    for (int i = 0; i < 10; i++) feed(4'(i), 12'd2048, i + 1);
    feed(4'd10, 12'd4095, 3);
    feed(4'd15, 12'd4095, 3);
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    for (int i = 0; i < 10; i++) exp_bins[i] = i + 1;
    chk_bins("map");

    // Same-edge sample belongs to the next window
    publish(1'b1, 4'd5, 12'd2048, lat, pulses);
    chk("same_edge_first", int'(bin_o[5]), 0);
    repeat (6) tick();
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    chk("same_edge_second", int'(bin_o[5]), 1);
    chk("same_edge_latency", lat, 11);

    // Overrun: flag at T+5 dropped, samples during busy kept
    feed(4'd7, 12'd2048, 5);
    set_values_flag = 1'b1;
    tick();                                 // edge T
    set_values_flag = 1'b0;
    chk("ovr_busy", int'(busy), 1);
    band_valid = 1'b1;
    band_idx   = 4'd2;
    band_mag   = 12'd2048;
    repeat (4) tick();                      // edges T+1..T+4
    set_values_flag = 1'b1;
    tick();                                 // edge T+5
    set_values_flag = 1'b0;
    band_valid      = 1'b0;
    chk("ovr_pulse", int'(overrun), 1);
    chk("ovr_busy_mid", int'(busy), 1);
    tick();                                 // edge T+6
    chk("ovr_pulse_end", int'(overrun), 0);
    lat = 0;
    pulses = 0;
    for (int c = 7; c <= 20; c++) begin
      tick();
      if (values_ready) begin
        pulses++;
        if (lat == 0) lat = c;
      end
    end
    chk("ovr_latency", lat, 11);
    chk("ovr_pulses", pulses, 1);
    set_all(0);
    exp_bins[7] = 5;
    chk_bins("ovr_first");
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    set_all(0);
    exp_bins[2] = 5;
    chk_bins("ovr_kept");

    // Reset mid-sequence
    feed(4'd4, 12'd2048, 3);
    set_values_flag = 1'b1;
    tick();
    set_values_flag = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    set_all(0);
    chk_bins("rst_mid");
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(values_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (values_ready) cnt++;
    end
    chk("rst_no_commit", cnt, 0);
    feed(4'd12, 12'd4095, 10);
    publish(1'b0, 4'd0, 12'd0, lat, pulses);
    chk_bins("rst_idx12");
    chk("rst_idx12_latency", lat, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
